hazard_track: RTL

HAZARD_TRACK -- requirements
Module: hazard_track

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/hazard_track_tag_stage_reg.sv | 36 +++
 rtl/hazard_track.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared pipeline types for the hazard tracking slice.
//   reg_idx_t    : 5-bit architectural register index
//   stage_tag_t  : per-stage tag {valid, rd, rd_valid, mem_read, mem_write}
//   mem_state_t  : data-memory handshake FSM state (IDLE / WAIT)
//   BUBBLE_TAG   : all-zero tag used for bubbles and reset
//   make_tag     : builds a tag, never reporting x0 as a destination
//   sat_inc32    : saturating 32-bit increment for event counters
package riscv_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     rd_valid;
    logic     mem_read;
    logic     mem_write;
  } stage_tag_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam stage_tag_t BUBBLE_TAG = '{
    valid:     1'b0,
    rd:        5'd0,
    rd_valid:  1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0
  };

  // rd_valid is forced low for x0 so downstream forwarding never matches it.
  function automatic stage_tag_t make_tag(
    input logic     valid,
    input reg_idx_t rd,
    input logic     rd_valid,
    input logic     mem_read,
    input logic     mem_write
  );
    stage_tag_t t;
    t.valid     = valid;
    t.rd        = rd;
    t.rd_valid  = rd_valid & (rd != 5'd0);
    t.mem_read  = mem_read;
    t.mem_write = mem_write;
    return t;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    logic [31:0] r;
    if (en && (v != 32'hFFFF_FFFF)) begin
      r = v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_track_tag_stage_reg.sv
// tag_stage_reg -- one pipeline-stage tag register.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset, loads a bubble
//   hold        : keep the current tag (highest priority after reset)
//   load_bubble : load a bubble instead of d
//   d           : incoming tag
//   q           : registered tag
module tag_stage_reg
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       hold,
  input  logic       load_bubble,
  input  stage_tag_t d,
  output stage_tag_t q
);

  stage_tag_t tag_r;

  // Tag register: reset > hold > bubble > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_r <= BUBBLE_TAG;
    end else if (hold) begin
      tag_r <= tag_r;
    end else if (load_bubble) begin
      tag_r <= BUBBLE_TAG;
    end else begin
      tag_r <= d;
    end
  end

  assign q = tag_r;

endmodule

// File: rtl/hazard_track.sv
// hazard_track -- tracks destination/memory tags through the E, M and W
// stages and generates the data-memory wait freeze.
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   issue_valid_d, rd_d, rd_valid_d, mem_read_d, mem_write_d : decode tag
//   stall_d               : load-use stall, bubbles E and holds fetch/decode
//   flush_e               : taken branch/jump resolved in E, bubbles E
//   dmem_ready            : data memory completes the current access
//   rd_e/m/w, rd_valid_e/m/w : per-stage destination and write flag
//   mem_read_e            : E holds a load
//   dmem_req              : M holds a memory access
//   freeze                : memory wait, holds F, D, E and M
//   en_fd                 : fetch/decode register enable
// Optional build macro HAZARD_TRACK_PERF_EN adds the saturating 32-bit
// counters bubble_cnt (stall cycles) and wait_cnt (freeze cycles).
module hazard_track
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid_d,
  input  reg_idx_t   rd_d,
  input  logic       rd_valid_d,
  input  logic       mem_read_d,
  input  logic       mem_write_d,
  input  logic       stall_d,
  input  logic       flush_e,
  input  logic       dmem_ready,
  output logic [4:0] rd_e,
  output logic [4:0] rd_m,
  output logic [4:0] rd_w,
  output logic       rd_valid_e,
  output logic       rd_valid_m,
  output logic       rd_valid_w,
  output logic       mem_read_e,
  output logic       dmem_req,
  output logic       freeze,
  output logic       en_fd
`ifdef HAZARD_TRACK_PERF_EN
  ,
  output logic [31:0] bubble_cnt,
  output logic [31:0] wait_cnt
`endif
);

  stage_tag_t d_tag_s;
  stage_tag_t e_tag_s;
  stage_tag_t m_tag_s;
  stage_tag_t w_tag_s;
  logic       e_bubble_s;
  logic       dmem_req_s;
  logic       freeze_s;
  mem_state_t state_r;
  mem_state_t state_next_s;
  logic       unused_s;

  assign d_tag_s    = make_tag(issue_valid_d, rd_d, rd_valid_d, mem_read_d, mem_write_d);
  // Flush and stall together still yield exactly one bubble; during a
  // freeze the E register holds, so a pending flush waits with the branch.
  assign e_bubble_s = flush_e | stall_d | ~issue_valid_d;
  assign dmem_req_s = m_tag_s.valid & (m_tag_s.mem_read | m_tag_s.mem_write);
  assign freeze_s   = dmem_req_s & ~dmem_ready;

  tag_stage_reg u_stage_e (
    .clk         (clk),
    .reset       (reset),
    .hold        (freeze_s),
    .load_bubble (e_bubble_s),
    .d           (d_tag_s),
    .q           (e_tag_s)
  );

  // flush_e deliberately does not touch the E-to-M move: the branch itself
  // continues down the pipe.
  tag_stage_reg u_stage_m (
    .clk         (clk),
    .reset       (reset),
    .hold        (freeze_s),
    .load_bubble (1'b0),
    .d           (e_tag_s),
    .q           (m_tag_s)
  );

  // W keeps moving during a freeze, draining a bubble each wait cycle.
  tag_stage_reg u_stage_w (
    .clk         (clk),
    .reset       (reset),
    .hold        (1'b0),
    .load_bubble (freeze_s),
    .d           (m_tag_s),
    .q           (w_tag_s)
  );

  // Memory FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= MEM_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Memory FSM next-state logic; a zero-wait access never leaves IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      MEM_IDLE: begin
        if (dmem_req_s && !dmem_ready) begin
          state_next_s = MEM_WAIT;
        end else begin
          state_next_s = MEM_IDLE;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_next_s = MEM_IDLE;
        end else begin
          state_next_s = MEM_WAIT;
        end
      end
      default: begin
        state_next_s = MEM_IDLE;
      end
    endcase
  end

  assign rd_e       = e_tag_s.rd;
  assign rd_m       = m_tag_s.rd;
  assign rd_w       = w_tag_s.rd;
  assign rd_valid_e = e_tag_s.rd_valid;
  assign rd_valid_m = m_tag_s.rd_valid;
  assign rd_valid_w = w_tag_s.rd_valid;
  assign mem_read_e = e_tag_s.mem_read;
  assign dmem_req   = dmem_req_s;
  assign freeze     = freeze_s;
  assign en_fd      = ~(freeze_s | stall_d);

  // W only needs rd and rd_valid downstream.
  assign unused_s = ^{w_tag_s.valid, w_tag_s.mem_read, w_tag_s.mem_write};

`ifdef HAZARD_TRACK_PERF_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] wait_cnt_r;

  // Saturating performance counters for stall bubbles and memory waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_r <= 32'd0;
      wait_cnt_r   <= 32'd0;
    end else begin
      bubble_cnt_r <= sat_inc32(bubble_cnt_r, stall_d & ~freeze_s);
      wait_cnt_r   <= sat_inc32(wait_cnt_r, freeze_s);
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign wait_cnt   = wait_cnt_r;
`endif

endmodule
